// File: rtl/icache_responder_pkg.sv
// ============================================================================
// Module      : icache_responder_pkg
// Description : Shared types for the instruction-cache responder: the
//               datapath word type, the controller state encoding and an
//               address-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_responder_pkg;

    // Datapath word
    typedef logic [31:0] word_t;

    // Controller states: serve hits in IDLE, fill one frame in FETCH
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    localparam int ICACHE_SETS_DEFAULT = 16;

    // Drop the byte offset so memory always sees a word address
    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_responder_if.sv
// ============================================================================
// Module      : icache_responder_if
// Description : Bundle of the datapath fetch port (imemREN/imemaddr/ihit/
//               imemload) and the memory-side read handshake
//               (iREN/iaddr/iwait/iload) around the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_responder_if;
    import icache_responder_pkg::*;

    // Datapath side
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    // Memory side
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // The cache: answers fetches, issues memory reads
    modport slave (
        input  imemREN,
        input  imemaddr,
        output ihit,
        output imemload,
        output iREN,
        output iaddr,
        input  iwait,
        input  iload
    );

    // The environment: fetch initiator plus memory controller
    modport master (
        output imemREN,
        output imemaddr,
        input  ihit,
        input  imemload,
        input  iREN,
        input  iaddr,
        output iwait,
        output iload
    );

endinterface

`default_nettype wire

// File: rtl/icache_responder_frame_array.sv
// ============================================================================
// Module      : icache_frame_array
// Description : SETS direct-mapped frames {valid, tag, data}. One
//               combinational read port by index, one synchronous write
//               port, valid bits cleared asynchronously on nRST. Tag and
//               data storage carry no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_frame_array
    import icache_responder_pkg::*;
#(
    parameter int SETS    = ICACHE_SETS_DEFAULT,
    parameter int IDX_W   = $clog2(SETS),
    parameter int TAG_W   = 30 - IDX_W,
    parameter int FRAME_W = 1 + TAG_W + 32
) (
    input  wire logic               CLK,
    input  wire logic               nRST,
    input  wire logic [IDX_W-1:0]   ridx,
    output logic      [FRAME_W-1:0] rframe,
    input  wire logic               wen,
    input  wire logic [IDX_W-1:0]   widx,
    input  wire logic [FRAME_W-1:0] wframe
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    word_t            data [SETS];

    // Valid bits: cleared by reset, set by a fill
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (wen) begin
            valid[widx] <= wframe[FRAME_W-1];
        end
    end

    // Tag and data storage: written on a fill only
    always_ff @(posedge CLK) begin
        if (wen) begin
            tags[widx] <= wframe[FRAME_W-2:32];
            data[widx] <= wframe[31:0];
        end
    end

    assign rframe = {valid[ridx], tags[ridx], data[ridx]};

endmodule

`default_nettype wire

// File: rtl/icache_responder.sv
// ============================================================================
// Module      : icache_responder
// Description : Direct-mapped, one-word-per-block instruction cache. Hits
//               return in the same cycle; a miss fetches the word over the
//               iREN/iwait handshake and the hit appears the cycle after
//               the fill. Optional hit/miss counters are built when
//               ICACHE_STATS_EN is defined; otherwise both read 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int SETS = ICACHE_SETS_DEFAULT
) (
    input  wire logic          CLK,
    input  wire logic          nRST,
    icache_responder_if.slave  bus,
    output word_t              hit_count,
    output word_t              miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } icachef_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } icache_frame_t;

    icache_state_t state, next_state;
    word_t         miss_addr, next_miss_addr;
    icachef_t      req, miss;
    icache_frame_t rframe, wframe;
    logic          wen;
    logic          hit;
    logic          unused_bits;

    assign req  = icachef_t'(bus.imemaddr);
    assign miss = icachef_t'(miss_addr);

    // Byte offsets never select anything in a one-word block
    assign unused_bits = ^{req.bytoff, miss.bytoff};

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .ridx   (req.idx),
        .rframe (rframe),
        .wen    (wen),
        .widx   (miss.idx),
        .wframe (wframe)
    );

    // State and latched miss address; iaddr is driven straight from miss_addr
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state     <= next_state;
            miss_addr <= next_miss_addr;
        end
    end

    // Hit detection, miss launch and fill completion
    always_comb begin
        next_state     = state;
        next_miss_addr = miss_addr;
        hit            = 1'b0;
        wen            = 1'b0;
        wframe         = '{valid: 1'b1, tag: miss.tag, data: bus.iload};
        bus.ihit       = 1'b0;
        bus.imemload   = '0;
        bus.iREN       = 1'b0;
        unique case (state)
            IDLE: begin
                hit = bus.imemREN && rframe.valid && (rframe.tag == req.tag);
                if (hit) begin
                    bus.ihit     = 1'b1;
                    bus.imemload = rframe.data;
                end else if (bus.imemREN) begin
                    next_miss_addr = word_align(bus.imemaddr);
                    next_state     = FETCH;
                end
            end
            FETCH: begin
                // The fill always lands on the latched address, whatever
                // the datapath is requesting now
                bus.iREN = 1'b1;
                if (!bus.iwait) begin
                    wen        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign bus.iaddr = miss_addr;

`ifdef ICACHE_STATS_EN
    // Free-running wrap-around hit and miss counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state == IDLE) && (next_state == FETCH)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

`default_nettype wire
